// File: rtl/btn_event_sched.sv
// Turns debounced button edges into ASCII event bytes ('0'+i press, 'a'+i release)
// and offers them one at a time on a valid/ready link, served round-robin.
module btn_event_sched #(
  parameter int N_BTN = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_BTN-1:0]   BTN_DBOUN,
  output logic               EVT_VALID,
  input  logic               EVT_READY,
  output logic [7:0]         EVT_CODE,
  output logic [2*N_BTN-1:0] PEND,
  output logic               OVF
);

  localparam int PW = (N_BTN > 2) ? $clog2(N_BTN) : 1;
  localparam logic [3:0] N4 = 4'(N_BTN);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t              state_r;
  logic [N_BTN-1:0]    prev_r;
  logic [PW-1:0]       ptr_r;
  logic [PW-1:0]       gidx_r;
  logic                grel_r;

  logic [N_BTN-1:0]    rise_s;
  logic [N_BTN-1:0]    fall_s;
  logic [2*N_BTN-1:0]  set_s;
  logic [2*N_BTN-1:0]  clr_s;
  logic [2*N_BTN-1:0]  pend_next_s;
  logic                lost_s;
  logic                hs_s;
  logic [N_BTN-1:0]    press_s;
  logic [N_BTN-1:0]    any_s;
  logic                found_s;
  logic [PW-1:0]       gnt_idx_s;
  logic                gnt_rel_s;

  // Edge detection and pending-flag update; a set on a bit being cleared wins.
  always_comb begin
    rise_s  = BTN_DBOUN & ~prev_r;
    fall_s  = ~BTN_DBOUN & prev_r;
    set_s   = {fall_s, rise_s};
    hs_s    = (state_r == OFFER) && EVT_READY;
    clr_s   = '0;
    for (int i = 0; i < N_BTN; i++) begin
      clr_s[i]         = hs_s && !grel_r && (gidx_r == PW'(i));
      clr_s[N_BTN + i] = hs_s &&  grel_r && (gidx_r == PW'(i));
    end
    pend_next_s = (PEND & ~clr_s) | set_s;
    lost_s      = |(set_s & PEND & ~clr_s);
  end

  // Round-robin search from ptr over buttons with either flag pending.
  always_comb begin
    logic [3:0] cand;
    press_s   = PEND[N_BTN-1:0];
    any_s     = PEND[N_BTN-1:0] | PEND[2*N_BTN-1:N_BTN];
    found_s   = 1'b0;
    gnt_idx_s = '0;
    gnt_rel_s = 1'b0;
    cand      = 4'd0;
    for (int j = 0; j < N_BTN; j++) begin
      cand = 4'(ptr_r) + 4'(j);
      if (cand >= N4) begin
        cand = cand - N4;
      end else begin
        cand = cand;
      end
      if (!found_s && any_s[cand[PW-1:0]]) begin
        found_s   = 1'b1;
        gnt_idx_s = cand[PW-1:0];
        gnt_rel_s = !press_s[cand[PW-1:0]];
      end else begin
        found_s   = found_s;
      end
    end
  end

  // Scheduler FSM with registered outputs; reset reloads prev to swallow held buttons.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= IDLE;
      prev_r    <= BTN_DBOUN;
      ptr_r     <= '0;
      gidx_r    <= '0;
      grel_r    <= 1'b0;
      PEND      <= '0;
      EVT_VALID <= 1'b0;
      EVT_CODE  <= 8'h00;
      OVF       <= 1'b0;
    end else begin
      prev_r <= BTN_DBOUN;
      PEND   <= pend_next_s;
      if (lost_s) begin
        OVF <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (found_s) begin
            gidx_r    <= gnt_idx_s;
            grel_r    <= gnt_rel_s;
            EVT_CODE  <= gnt_rel_s ? (8'h61 + 8'(gnt_idx_s)) : (8'h30 + 8'(gnt_idx_s));
            EVT_VALID <= 1'b1;
            state_r   <= OFFER;
          end
        end
        OFFER: begin
          if (EVT_READY) begin
            EVT_VALID <= 1'b0;
            state_r   <= IDLE;
            ptr_r     <= (gidx_r == PW'(N_BTN - 1)) ? '0 : (gidx_r + PW'(1));
          end
        end
        default: begin
          EVT_VALID <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_event_sched.sv
// Directed bench for btn_event_sched with N_BTN=4; inputs change and outputs are
// sampled 1 ns after each rising edge.
module tb_btn_event_sched;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] BTN_DBOUN = 4'b0000;
  logic       EVT_VALID;
  logic       EVT_READY = 1'b0;
  logic [7:0] EVT_CODE;
  logic [7:0] PEND;
  logic       OVF;

  int checks = 0;
  int errors = 0;

  btn_event_sched #(.N_BTN(4)) dut (
    .CLK(CLK), .RST(RST), .BTN_DBOUN(BTN_DBOUN), .EVT_VALID(EVT_VALID),
    .EVT_READY(EVT_READY), .EVT_CODE(EVT_CODE), .PEND(PEND), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] btn);
    BTN_DBOUN = btn;
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    EVT_READY = 1'b0;
    do_reset(4'b0000);
    tick();
    checks++;
    if ({EVT_VALID, EVT_CODE, PEND, OVF} !== 18'd0) begin
      errors++;
      $display("FAIL reset: valid=%b code=%h pend=%h ovf=%b, expected all zero", EVT_VALID, EVT_CODE, PEND, OVF);
    end
  endtask

  task automatic test_single_press();
    EVT_READY = 1'b1;
    BTN_DBOUN = 4'b0100;
    tick();
    checks++;
    if (EVT_VALID !== 1'b0 || PEND !== 8'h04) begin
      errors++;
      $display("FAIL press_pend: valid=%b pend=%h, expected 0 04", EVT_VALID, PEND);
    end
    tick();
    checks++;
    if (EVT_VALID !== 1'b1 || EVT_CODE !== 8'h32) begin
      errors++;
      $display("FAIL press_offer: valid=%b code=%h, expected 1 32", EVT_VALID, EVT_CODE);
    end
    tick();
    checks++;
    if (EVT_VALID !== 1'b0 || PEND !== 8'h00) begin
      errors++;
      $display("FAIL press_done: valid=%b pend=%h, expected 0 00", EVT_VALID, PEND);
    end
    tick();
    BTN_DBOUN = 4'b0000;
    tick();
    checks++;
    if (EVT_VALID !== 1'b0 || PEND !== 8'h40) begin
      errors++;
      $display("FAIL release_pend: valid=%b pend=%h, expected 0 40", EVT_VALID, PEND);
    end
    tick();
    checks++;
    if (EVT_VALID !== 1'b1 || EVT_CODE !== 8'h63) begin
      errors++;
      $display("FAIL release_offer: valid=%b code=%h, expected 1 63", EVT_VALID, EVT_CODE);
    end
    tick();
    checks++;
    if (EVT_VALID !== 1'b0 || PEND !== 8'h00) begin
      errors++;
      $display("FAIL release_done: valid=%b pend=%h, expected 0 00", EVT_VALID, PEND);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(4'b0000);
    EVT_READY = 1'b1;
    BTN_DBOUN = 4'b1111;
    tick();
    checks++;
    if (PEND !== 8'h0F) begin
      errors++;
      $display("FAIL b2b_pend: pend=%h, expected 0f", PEND);
    end
    for (int e = 0; e < 4; e++) begin
      tick();
      checks++;
      if (EVT_VALID !== 1'b1 || EVT_CODE !== 8'(8'h30 + e)) begin
        errors++;
        $display("FAIL b2b_offer%0d: valid=%b code=%h, expected 1 %h", e, EVT_VALID, EVT_CODE, 8'(8'h30 + e));
      end
      tick();
      checks++;
      if (EVT_VALID !== 1'b0) begin
        errors++;
        $display("FAIL b2b_gap%0d: valid=%b, expected 0", e, EVT_VALID);
      end
    end
    checks++;
    if (PEND !== 8'h00) begin
      errors++;
      $display("FAIL b2b_end: pend=%h, expected 00", PEND);
    end
  endtask

  task automatic test_hold();
    EVT_READY = 1'b0;
    do_reset(4'b0000);
    BTN_DBOUN = 4'b0010;
    tick();
    tick();
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (EVT_VALID !== 1'b1 || EVT_CODE !== 8'h31) begin
        errors++;
        $display("FAIL hold%0d: valid=%b code=%h, expected 1 31", c, EVT_VALID, EVT_CODE);
      end
      tick();
    end
    EVT_READY = 1'b1;
    tick();
    checks++;
    if (EVT_VALID !== 1'b0 || PEND[1] !== 1'b0) begin
      errors++;
      $display("FAIL hold_accept: valid=%b pend1=%b, expected 0 0", EVT_VALID, PEND[1]);
    end
  endtask

  task automatic test_overflow();
    EVT_READY = 1'b0;
    do_reset(4'b0000);
    BTN_DBOUN = 4'b0001;
    tick();
    BTN_DBOUN = 4'b0000;
    tick();
    BTN_DBOUN = 4'b0001;
    tick();
    checks++;
    if (OVF !== 1'b1 || PEND !== 8'h11 || EVT_VALID !== 1'b1 || EVT_CODE !== 8'h30) begin
      errors++;
      $display("FAIL ovf_set: ovf=%b pend=%h valid=%b code=%h, expected 1 11 1 30", OVF, PEND, EVT_VALID, EVT_CODE);
    end
    EVT_READY = 1'b1;
    tick();
    checks++;
    if (EVT_VALID !== 1'b0 || PEND !== 8'h10) begin
      errors++;
      $display("FAIL ovf_first: valid=%b pend=%h, expected 0 10", EVT_VALID, PEND);
    end
    tick();
    checks++;
    if (EVT_VALID !== 1'b1 || EVT_CODE !== 8'h61) begin
      errors++;
      $display("FAIL ovf_second: valid=%b code=%h, expected 1 61", EVT_VALID, EVT_CODE);
    end
    tick();
    checks++;
    if (PEND !== 8'h00 || OVF !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: pend=%h ovf=%b, expected 00 1", PEND, OVF);
    end
  endtask

  task automatic test_set_wins();
    EVT_READY = 1'b1;
    do_reset(4'b0000);
    BTN_DBOUN = 4'b0001;
    tick();
    BTN_DBOUN = 4'b0000;
    tick();
    BTN_DBOUN = 4'b0001;
    tick();
    checks++;
    if (PEND !== 8'h11 || OVF !== 1'b0 || EVT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL setwin: pend=%h ovf=%b valid=%b, expected 11 0 0", PEND, OVF, EVT_VALID);
    end
    tick();
    checks++;
    if (EVT_VALID !== 1'b1 || EVT_CODE !== 8'h30) begin
      errors++;
      $display("FAIL setwin_wrap: valid=%b code=%h, expected 1 30", EVT_VALID, EVT_CODE);
    end
    tick();
    tick();
    checks++;
    if (EVT_VALID !== 1'b1 || EVT_CODE !== 8'h61) begin
      errors++;
      $display("FAIL setwin_rel: valid=%b code=%h, expected 1 61", EVT_VALID, EVT_CODE);
    end
    tick();
  endtask

  task automatic test_reset_held();
    EVT_READY = 1'b1;
    BTN_DBOUN = 4'b0101;
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (EVT_VALID !== 1'b0) begin
        errors++;
        $display("FAIL held_valid%0d: valid=%b, expected 0", c, EVT_VALID);
      end
    end
    checks++;
    if (PEND !== 8'h00) begin
      errors++;
      $display("FAIL held_pend: pend=%h, expected 00", PEND);
    end
  endtask

  task automatic test_reset_mid();
    EVT_READY = 1'b0;
    BTN_DBOUN = 4'b0111;
    tick();
    BTN_DBOUN = 4'b0101;
    tick();
    BTN_DBOUN = 4'b0111;
    tick();
    checks++;
    if (EVT_VALID !== 1'b1 || EVT_CODE !== 8'h31 || OVF !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: valid=%b code=%h ovf=%b, expected 1 31 1", EVT_VALID, EVT_CODE, OVF);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if (EVT_VALID !== 1'b0 || PEND !== 8'h00 || OVF !== 1'b0 || EVT_CODE !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: valid=%b pend=%h ovf=%b code=%h, expected 0 00 0 00", EVT_VALID, PEND, OVF, EVT_CODE);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_back_to_back();
    test_hold();
    test_overflow();
    test_set_wins();
    test_reset_held();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_event_sched.md
BTN_EVENT_SCHED -- requirements
Module: btn_event_sched

Interface
REQ-001 The block SHALL have one parameter: N_BTN, default 4, number of debounced button inputs (legal range 2..8).
REQ-002 The block SHALL have port CLK, input, 1 bit: system clock (100 MHz); every register is clocked on the rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port BTN_DBOUN, input, N_BTN bits: debounced, CLK-synchronous button levels.
REQ-005 The block SHALL have port EVT_VALID, output, 1 bit: an event byte is offered.
REQ-006 The block SHALL have port EVT_READY, input, 1 bit: the consumer (UART transmitter) accepts the byte.
REQ-007 The block SHALL have port EVT_CODE, output, 8 bits: ASCII event byte.
REQ-008 The block SHALL have port PEND, output, 2*N_BTN bits: pending flags; [i] = press of button i, [N_BTN+i] = release of button i.
REQ-009 The block SHALL have port OVF, output, 1 bit: sticky flag, set when an event was lost by merging.

Function
REQ-010 A prev register SHALL hold BTN_DBOUN from the previous cycle; a rise on bit i (prev=0, cur=1) is a press event and a fall is a release event.
REQ-011 A press or release edge detected at edge k SHALL set its PEND bit, and the bit SHALL be visible after edge k.
REQ-012 The FSM SHALL have exactly two states: IDLE and OFFER.
REQ-013 In IDLE with PEND nonzero at edge k, the block SHALL grant one button, latch EVT_CODE, go to OFFER and drive EVT_VALID=1 after edge k (press-to-VALID latency 2 cycles from the first sampled level change).
REQ-014 Grant SHALL be round-robin over button index: search starts at ptr and wraps N_BTN-1 -> 0; the first index with either pending bit wins.
REQ-015 Within the granted button, press SHALL win over release.
REQ-016 EVT_CODE SHALL be 0x30+i ('0'+i) for a press and 0x61+i ('a'+i) for a release.
REQ-017 In OFFER, EVT_VALID and EVT_CODE SHALL be held stable until EVT_READY=1.
REQ-018 At the handshake edge (VALID&READY), the block SHALL clear the served PEND bit, set ptr to granted index+1 (mod N_BTN), return to IDLE, and drive EVT_VALID=0 for at least one cycle.
REQ-019 Back-to-back events SHALL therefore be offered every 2 cycles when EVT_READY is held at 1.
REQ-020 A new edge for a PEND bit that is cleared at the same edge SHALL leave the bit set (set wins), with no OVF.
REQ-021 A new edge for a PEND bit already set and not being cleared SHALL leave the bit set and set OVF.
REQ-022 A press and a release of the same button SHALL be separate flags, so press-then-release while waiting yields two events, press first.
REQ-023 EVT_READY asserted while EVT_VALID=0 SHALL have no effect.

Reset
REQ-024 When RST=1 at an edge, the block SHALL set state=IDLE, PEND=0, EVT_VALID=0, EVT_CODE=0x00, OVF=0, ptr=0.
REQ-025 When RST=1 at an edge, prev SHALL load the current BTN_DBOUN, so buttons held through reset produce no event.
REQ-026 Reset SHALL override all other activity, including an offer mid-handshake; the offered event is discarded.
REQ-027 OVF SHALL clear only on reset.

Verification
REQ-028 The bench SHALL cover: N_BTN=4, EVT_READY=1, BTN_DBOUN[2] 0->1 -> EVT_VALID high 2 cycles later for 1 cycle with EVT_CODE=0x32; later 1->0 -> EVT_CODE=0x63.
REQ-029 The bench SHALL cover: BTN_DBOUN 0000->1111 in one cycle, EVT_READY=1, ptr=0 -> codes 0x30, 0x31, 0x32, 0x33, 2 cycles apart, PEND ends 0.
REQ-030 The bench SHALL cover: EVT_READY=0 for 10 cycles during an offer of 0x31 -> EVT_VALID and EVT_CODE constant; EVT_READY=1 -> accepted, PEND[1]=0 next cycle.
REQ-031 The bench SHALL cover: with EVT_READY=0, button 0 press, release, press -> OVF=1, PEND[0]=1 and PEND[4]=1; on release of EVT_READY, outputs 0x30 then 0x61.
REQ-032 The bench SHALL cover: BTN_DBOUN=0101 held through RST, then RST deasserted -> no EVT_VALID for 20 cycles, PEND=0.
REQ-033 The bench SHALL cover: RST pulsed while EVT_VALID=1 -> next cycle EVT_VALID=0, PEND=0, OVF=0, EVT_CODE=0x00.
